// File: rtl/matrix_job_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_job_sequencer
//
// Runs one matrix job on the coprocessor datapath. It reads the packed operand
// words {B[i],A[i]} from the shared single-port 16-bit memory, starts the
// matrix ALU, and waits the ALU's fixed latency. It then writes the result
// bytes back, each zero-extended to 16 bits, followed by one overflow word.
// Toward the command source it uses a valid/ready handshake. Requests that
// arrive while a job is running are ignored.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   cmd_valid       job request (accepted when cmd_ready is high)
//   cmd_ready       high only while idle
//   cmd_op          ALU op code, latched on accept
//   cmd_size        matrix size code (00=2x2 .. 11=5x5), latched on accept
//   mem_addr        memory address (registered)
//   mem_wren        memory write enable (registered)
//   mem_wdata       memory write data (registered)
//   mem_rdata       memory read data, valid the cycle after mem_addr
//   alu_op          latched op code
//   alu_size        latched size code
//   alu_matrix_a/b  operands, element i at bits [8i+7:8i]
//   alu_start       one-cycle ALU start pulse
//   alu_result      ALU result, same packing as the operands
//   alu_overflow    ALU overflow flag
//   busy            high in every state except idle
//   done            one-cycle pulse at job completion
//   perf_cycles     (MATSEQ_PERF_CNT_EN only) busy-cycle count of the last job
//   ovf_flag        overflow of the last completed job, held until next accept
//
// Build option: define MATSEQ_PERF_CNT_EN to add the perf_cycles counter.
// -----------------------------------------------------------------------------
module matrix_job_sequencer #(
    parameter int ADDR_W      = 7,
    parameter int ELEMS       = 25,
    parameter int OPND_BASE   = 0,
    parameter int RESULT_BASE = 25,
    parameter int ALU_LATENCY = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [1:0]         cmd_size,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wren,
    output logic [15:0]        mem_wdata,
    input  logic [15:0]        mem_rdata,
    output logic [2:0]         alu_op,
    output logic [1:0]         alu_size,
    output logic [8*ELEMS-1:0] alu_matrix_a,
    output logic [8*ELEMS-1:0] alu_matrix_b,
    output logic               alu_start,
    input  logic [8*ELEMS-1:0] alu_result,
    input  logic               alu_overflow,
    output logic               busy,
    output logic               done,
`ifdef MATSEQ_PERF_CNT_EN
    output logic [15:0]        perf_cycles,
`endif
    output logic               ovf_flag
);

    localparam int IDX_W = $clog2(ELEMS);
    localparam int CNT_W = 7;  // holds ALU_LATENCY-1 for latencies up to 127
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ELEMS - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(ALU_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAPT,
        ALU_START,
        ALU_WAIT,
        WR,
        WR_OVF,
        DONE
    } state_t;

    state_t                state, state_next;
    logic [IDX_W-1:0]      index;
    logic [CNT_W-1:0]      wait_cnt;
    logic [8*ELEMS-1:0]    result;
    logic                  ovf;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // NOTE: registers are updated only with non-blocking assignments, so every
    // always_ff block reads the pre-edge value of every register it uses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: the default comes first so that no path through the case can
        // leave state_next unassigned. Without it, a latch would be inferred.
        state_next = state;
        case (state)
            IDLE:      if (cmd_valid) state_next = RD_ADDR;
            RD_ADDR:   state_next = RD_CAPT;
            RD_CAPT:   state_next = (index == LAST_IDX) ? ALU_START : RD_ADDR;
            ALU_START: state_next = ALU_WAIT;
            ALU_WAIT:  if (wait_cnt == LAST_WAIT) state_next = WR;
            WR:        if (index == LAST_IDX) state_next = WR_OVF;
            WR_OVF:    state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // The memory and ALU outputs are registered. Each one is loaded on the
    // edge that enters the state where the value is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr     <= '0;
            mem_wren     <= 1'b0;
            mem_wdata    <= '0;
            alu_op       <= '0;
            alu_size     <= '0;
            alu_matrix_a <= '0;
            alu_matrix_b <= '0;
            alu_start    <= 1'b0;
            done         <= 1'b0;
            ovf_flag     <= 1'b0;
            index        <= '0;
            wait_cnt     <= '0;
            result       <= '0;
            ovf          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_op   <= cmd_op;
                        alu_size <= cmd_size;
                        ovf_flag <= 1'b0;
                        mem_addr <= ADDR_W'(OPND_BASE);
                        index    <= '0;
                    end
                end
                RD_CAPT: begin
                    alu_matrix_a[8*index +: 8] <= mem_rdata[7:0];
                    alu_matrix_b[8*index +: 8] <= mem_rdata[15:8];
                    if (index != LAST_IDX) begin
                        index    <= index + 1'b1;
                        mem_addr <= ADDR_W'(OPND_BASE + int'(index) + 1);
                    end else begin
                        index     <= '0;
                        alu_start <= 1'b1;
                    end
                end
                ALU_START: begin
                    alu_start <= 1'b0;
                    wait_cnt  <= '0;
                end
                ALU_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == LAST_WAIT) begin
                        result    <= alu_result;
                        ovf       <= alu_overflow;
                        // Element 0 is taken straight from the ALU bus because
                        // the result register loads on this same edge.
                        mem_wren  <= 1'b1;
                        mem_addr  <= ADDR_W'(RESULT_BASE);
                        mem_wdata <= {8'h00, alu_result[7:0]};
                    end
                end
                WR: begin
                    if (index != LAST_IDX) begin
                        index     <= index + 1'b1;
                        mem_addr  <= ADDR_W'(RESULT_BASE + int'(index) + 1);
                        mem_wdata <= {8'h00, result[8*(int'(index) + 1) +: 8]};
                    end else begin
                        index     <= '0;
                        mem_addr  <= ADDR_W'(RESULT_BASE + ELEMS);
                        mem_wdata <= {15'b0, ovf};
                    end
                end
                WR_OVF: begin
                    mem_wren <= 1'b0;
                    done     <= 1'b1;
                    ovf_flag <= ovf;
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef MATSEQ_PERF_CNT_EN
    // The DONE cycle is not counted. This makes the final value equal to the
    // number of edges from accept to the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (state == IDLE) begin
            if (cmd_valid) perf_cycles <= '0;
        end else if (state != DONE && perf_cycles != 16'hFFFF) begin
            perf_cycles <= perf_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_job_sequencer
//
// Self-checking bench for matrix_job_sequencer. It models the shared memory
// and a fixed-latency ALU. The ALU model drives the correct result only during
// the one cycle that ends exactly LAT cycles after the start pulse, and drives
// the inverted value at all other times. Operands, op codes and ALU behaviour
// are randomized per job. Expected values come from the bench's own operand
// tables.
// -----------------------------------------------------------------------------
module tb_matrix_job_sequencer #(
    parameter int LAT = 5
);

    localparam int ELEMS  = 25;
    localparam int RBASE  = 25;
    localparam int ADDR_W = 7;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [1:0]         cmd_size;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_wren;
    logic [15:0]        mem_wdata;
    logic [15:0]        mem_rdata;
    logic [2:0]         alu_op;
    logic [1:0]         alu_size;
    logic [8*ELEMS-1:0] alu_matrix_a;
    logic [8*ELEMS-1:0] alu_matrix_b;
    logic               alu_start;
    logic [8*ELEMS-1:0] alu_result;
    logic               alu_overflow;
    logic               busy;
    logic               done;
    logic               ovf_flag;
`ifdef MATSEQ_PERF_CNT_EN
    logic [15:0]        perf_cycles;
`endif

    int errors = 0;
    int checks = 0;

    // Operand words live in opnd[] (written by the bench only). Writes from the
    // DUT land in res[], which the bench then inspects.
    logic [15:0] opnd [0:127];
    logic [15:0] res  [0:127];
    logic [7:0]  exp_a [0:ELEMS-1];
    logic [7:0]  exp_b [0:ELEMS-1];

    // ALU model controls: mode 0 -> A+B per byte, mode 1 -> constant 0xF0.
    bit                 alu_mode;
    bit                 alu_ovf;
    logic [7:0]         lat_cnt;
    logic [8*ELEMS-1:0] good_result;

    matrix_job_sequencer #(
        .ADDR_W      (ADDR_W),
        .ELEMS       (ELEMS),
        .OPND_BASE   (0),
        .RESULT_BASE (RBASE),
        .ALU_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_size     (cmd_size),
        .mem_addr     (mem_addr),
        .mem_wren     (mem_wren),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .alu_op       (alu_op),
        .alu_size     (alu_size),
        .alu_matrix_a (alu_matrix_a),
        .alu_matrix_b (alu_matrix_b),
        .alu_start    (alu_start),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .busy         (busy),
        .done         (done),
`ifdef MATSEQ_PERF_CNT_EN
        .perf_cycles  (perf_cycles),
`endif
        .ovf_flag     (ovf_flag)
    );

    always #5 clk = ~clk;

    // Single-port memory: the read data shows up one cycle after the address.
    always @(posedge clk) begin
        if (mem_wren) res[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_addr < ADDR_W'(RBASE)) ? opnd[mem_addr] : res[mem_addr];
    end

    // ALU model. lat_cnt counts the cycles since the start pulse was seen.
    always @(posedge clk or posedge rst) begin
        if (rst)                                lat_cnt <= 8'd0;
        else if (alu_start)                     lat_cnt <= 8'd1;
        else if (lat_cnt != 0 && lat_cnt != 255) lat_cnt <= lat_cnt + 8'd1;
    end

    always @* begin
        good_result = '0;
        for (int i = 0; i < ELEMS; i++)
            good_result[8*i +: 8] = alu_mode ? 8'hF0
                                  : 8'(alu_matrix_a[8*i +: 8] + alu_matrix_b[8*i +: 8]);
    end

    assign alu_result   = (lat_cnt == 8'(LAT)) ? good_result : ~good_result;
    assign alu_overflow = (lat_cnt == 8'(LAT)) ? alu_ovf : ~alu_ovf;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic load_ops(input bit directed);
        for (int i = 0; i < ELEMS; i++) begin
            exp_a[i] = directed ? 8'(i)     : 8'($urandom);
            exp_b[i] = directed ? 8'(2 * i) : 8'($urandom);
            opnd[i]  = {exp_b[i], exp_a[i]};
        end
    endtask

    // Call at a negedge with the DUT idle. If hold is set, cmd_valid stays
    // high, so the edge after the final negedge accepts the next job.
    task automatic do_job(input logic [2:0] op, input logic [1:0] sz,
                          input bit mode, input bit ovf, input bit hold);
        int   edges;
        int   starts;
        int   extra;
        bit   seen;
        logic [7:0]         eb;
        logic [8*ELEMS-1:0] va;
        logic [8*ELEMS-1:0] vb;
        alu_mode = mode;
        alu_ovf  = ovf;
        check("ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_size  = sz;
        @(posedge clk);
        @(negedge clk);
        edges = 0;
        check("ovf_clr", ovf_flag, 1'b0);
        check("busy", busy, 1'b1);
        if (!hold) cmd_valid = 1'b0;
        starts = 0;
        extra  = 0;
        seen   = 1'b0;
        while (!seen && edges < 400) begin
            if (alu_start) starts++;
            if (cmd_valid && cmd_ready) extra++;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                edges++;
            end
        end
        check("done_seen", seen, 1'b1);
        check("latency", edges, 77 + LAT);
        check("start_pulses", starts, 1);
        check("extra_accept", extra, 0);
        check("ready_in_done", cmd_ready, 1'b0);
        @(negedge clk);
        check("done_width", done, 1'b0);
        check("ready_after", cmd_ready, 1'b1);
        check("ovf_flag", ovf_flag, ovf);
        check("alu_op", alu_op, op);
        check("alu_size", alu_size, sz);
`ifdef MATSEQ_PERF_CNT_EN
        check("perf", perf_cycles, 77 + LAT);
`endif
        for (int i = 0; i < ELEMS; i++) begin
            va[8*i +: 8] = exp_a[i];
            vb[8*i +: 8] = exp_b[i];
        end
        check("matrix_a", alu_matrix_a, va);
        check("matrix_b", alu_matrix_b, vb);
        for (int i = 0; i < ELEMS; i++) begin
            eb = mode ? 8'hF0 : 8'(exp_a[i] + exp_b[i]);
            check($sformatf("wr_res[%0d]", RBASE + i), res[RBASE + i], {8'h00, eb});
        end
        check("wr_ovf", res[RBASE + ELEMS], {15'b0, ovf});
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_size  = '0;
        alu_mode  = 1'b0;
        alu_ovf   = 1'b0;
        for (int i = 0; i < 128; i++) begin
            opnd[i] = 16'h0;
        end
        repeat (3) @(negedge clk);

        // Values held during reset
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wren", mem_wren, 1'b0);
        check("rst_addr", mem_addr, 7'd0);
        check("rst_wdata", mem_wdata, 16'd0);
        check("rst_start", alu_start, 1'b0);
        check("rst_ovf", ovf_flag, 1'b0);
        check("rst_mat_a", alu_matrix_a, '0);
`ifdef MATSEQ_PERF_CNT_EN
        check("rst_perf", perf_cycles, 16'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed job: A=i, B=2i, ALU computes A+B, no overflow
        load_ops(1'b1);
        do_job(3'd0, 2'b11, 1'b0, 1'b0, 1'b0);

        // Directed job: overflow set, constant 0xF0 result
        load_ops(1'b1);
        do_job(3'd0, 2'b11, 1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("ovf_hold", ovf_flag, 1'b1);
`ifdef MATSEQ_PERF_CNT_EN
        check("perf_idle", perf_cycles, 77 + LAT);
`endif

        // cmd_valid held high across a job, then back-to-back accept
        load_ops(1'b0);
        do_job(3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)), 1'b0, 1'b0, 1'b1);
        do_job(3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)), 1'b1, 1'b1, 1'b0);

        // Reset asserted mid-cycle during the write phase
        load_ops(1'b0);
        alu_mode  = 1'b0;
        alu_ovf   = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (60 + LAT) @(negedge clk);
        check("wren_before_rst", mem_wren, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort_wren", mem_wren, 1'b0);
        check("abort_ready", cmd_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_addr", mem_addr, 7'd0);
        check("abort_mat_a", alu_matrix_a, '0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (100) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("abort_no_done", nd, 0);

        // Randomized jobs
        repeat (3) begin
            load_ops(1'b0);
            do_job(3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)),
                   1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0);
            repeat ($urandom_range(4, 0)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
